// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register, instruction fetch FSM and field split
//
// Purpose : owns the PC, fetches one word at a time from instruction memory
//           over a req/ack handshake, holds the fetched word until the core
//           commits it, and exposes op/funct3/funct7b5 to the control unit.
// Macro   : FETCH_PERF_CNT_EN adds the CNT_W parameter, the fetch_count port
//           and its committed-instruction counter.
// Ports   : clk, reset (sync, active-high)
//           PCSrc, PCTarget, advance      - next-PC selection and commit
//           imem_req, imem_addr           - fetch request / address (= PC)
//           imem_rdata, imem_ack          - memory response
//           Instr, instr_valid, PC, PCPlus4, op, funct3, funct7b5
//           fetch_err, err_code           - sticky error (01 misaligned, 10 timeout)
//           fetch_count                   - optional commit counter
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
`ifdef FETCH_PERF_CNT_EN
    , parameter int        CNT_W       = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        fetch_err,
    output logic [1:0]  err_code
`ifdef FETCH_PERF_CNT_EN
    , output logic [CNT_W-1:0] fetch_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_TRAP = 2'd3;

    localparam int          TW      = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        code_d  = code_q;
        tcnt_d  = tcnt_q;
`ifdef FETCH_PERF_CNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_HOLD;
                end else if (tcnt_q == TO_LAST) begin
                    // This was the ACK_TIMEOUT-th cycle with req high and no ack.
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    state_d = S_TRAP;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (advance) begin
                    valid_d = 1'b0;
                    if (!PCSrc || (PCTarget[1:0] == 2'b00)) begin
                        pc_d    = PCSrc ? PCTarget : pc_plus4;
                        state_d = S_REQ;
`ifdef FETCH_PERF_CNT_EN
                        cnt_d   = cnt_q + CNT_W'(1);
`endif
                    end else begin
                        // PC keeps the address of the faulting branch.
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = S_TRAP;
                    end
                end
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            tcnt_q  <= '0;
`ifdef FETCH_PERF_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            tcnt_q  <= tcnt_d;
`ifdef FETCH_PERF_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign fetch_err   = err_q;
    assign err_code    = code_q;
`ifdef FETCH_PERF_CNT_EN
    assign fetch_count = cnt_q;
`endif

endmodule
